// File: rtl/string_buffer_writer.sv
// string_buffer_writer
// Host-side writer and owner of the character RAM that string renderers read.
// Host commands arrive over a valid/ready handshake:
//   00 SET_PTR  : move the write pointer (also clears the wrapped flag)
//   01 PUT_CHAR : write one byte at the pointer and advance
//   10 PUT_LAST : write one byte, advance, then write a 8'h00 terminator
//                 at the new pointer without advancing past it
//   11 CLEAR    : zero cmd_len+1 bytes starting at cmd_addr, then park the
//                 pointer at cmd_addr
// The renderer read port (char_addr -> char_data) has 1-clock latency and
// runs every cycle regardless of the command state.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_op/addr/data/len  command fields, sampled on the accept cycle
//   char_addr         renderer read address
//   char_data         registered read data
//   wr_ptr            current write pointer
//   busy              TERM or CLEAR in progress
//   wrapped           sticky: wr_ptr stepped from DEPTH-1 to 0
//
// Optional feature macro: STRBUF_WRFWD_EN
//   defined   -> write-first: a same-cycle write to char_addr is forwarded
//   undefined -> read-first: char_data shows the pre-write byte
module string_buffer_writer #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_data,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [ADDR_W-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              wrapped
);

    localparam logic [1:0] OP_SET_PTR  = 2'b00;
    localparam logic [1:0] OP_PUT_CHAR = 2'b01;
    localparam logic [1:0] OP_PUT_LAST = 2'b10;
    localparam logic [1:0] OP_CLEAR    = 2'b11;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TERM  = 2'b01,
        CLEAR = 2'b10
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] caddr_reg;
    logic [ADDR_W-1:0] count_reg;
    logic [ADDR_W-1:0] start_reg;
    logic              busy_reg;
    logic              wrapped_reg;
    logic [7:0]        char_data_reg;

    logic [7:0]        mem [DEPTH];

    logic              fire;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;

    // Address step that wraps at DEPTH even when DEPTH < 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    assign cmd_ready = (state_reg == IDLE);
    assign fire      = cmd_valid && cmd_ready;

    // Single RAM write port shared by appends, the terminator and clears.
    always_comb begin
        we    = 1'b0;
        waddr = wr_ptr_reg;
        wdata = cmd_data;
        case (state_reg)
            IDLE: begin
                if (fire && (cmd_op == OP_PUT_CHAR || cmd_op == OP_PUT_LAST))
                    we = 1'b1;
            end
            TERM: begin
                we    = 1'b1;
                wdata = 8'h00;
            end
            CLEAR: begin
                we    = 1'b1;
                waddr = caddr_reg;
                wdata = 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Registered read; the RAM array reads its pre-write value this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            char_data_reg <= 8'h00;
        end else begin
`ifdef STRBUF_WRFWD_EN
            if (we && (waddr == char_addr))
                char_data_reg <= wdata;
            else
                char_data_reg <= mem[char_addr];
`else
            char_data_reg <= mem[char_addr];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            caddr_reg   <= '0;
            count_reg   <= '0;
            start_reg   <= '0;
            busy_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        case (cmd_op)
                            OP_SET_PTR: begin
                                wr_ptr_reg  <= cmd_addr;
                                wrapped_reg <= 1'b0;
                            end
                            OP_PUT_CHAR: begin
                                wr_ptr_reg <= step_addr(wr_ptr_reg);
                                if (wr_ptr_reg == LAST_ADDR)
                                    wrapped_reg <= 1'b1;
                            end
                            OP_PUT_LAST: begin
                                wr_ptr_reg <= step_addr(wr_ptr_reg);
                                if (wr_ptr_reg == LAST_ADDR)
                                    wrapped_reg <= 1'b1;
                                state_reg <= TERM;
                                busy_reg  <= 1'b1;
                            end
                            default: begin
                                count_reg <= cmd_len;
                                caddr_reg <= cmd_addr;
                                start_reg <= cmd_addr;
                                state_reg <= CLEAR;
                                busy_reg  <= 1'b1;
                            end
                        endcase
                    end
                end
                TERM: begin
                    // Terminator lands at wr_ptr; pointer stays so the next
                    // append overwrites it.
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                CLEAR: begin
                    if (count_reg == '0) begin
                        wr_ptr_reg <= start_reg;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end else begin
                        count_reg <= count_reg - 1'b1;
                        caddr_reg <= step_addr(caddr_reg);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign char_data = char_data_reg;
    assign wr_ptr    = wr_ptr_reg;
    assign busy      = busy_reg;
    assign wrapped   = wrapped_reg;

endmodule

// File: tb/tb_string_buffer_writer.sv
module tb_string_buffer_writer;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_PUT  = 2'b01;
    localparam logic [1:0] OP_LAST = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_data;
    logic [AW-1:0] cmd_len;
    logic [AW-1:0] char_addr;
    logic [7:0]    char_data;
    logic [AW-1:0] wr_ptr;
    logic          busy;
    logic          wrapped;

    string_buffer_writer #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .char_addr (char_addr),
        .char_data (char_data),
        .wr_ptr    (wr_ptr),
        .busy      (busy),
        .wrapped   (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain byte array plus pointer and wrap flag.
    logic [7:0] model_mem [DEPTH];
    int         model_ptr;
    bit         model_wrapped;

    int vector_cnt    = 0;
    int miscompare_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // High-level effect of one command on the model.
    task automatic model_apply(input logic [1:0] op, input int addr, input logic [7:0] data,
                               input int len);
        case (op)
            OP_SET: begin
                model_ptr     = addr;
                model_wrapped = 0;
            end
            OP_PUT, OP_LAST: begin
                model_mem[model_ptr] = data;
                model_ptr = (model_ptr + 1) % DEPTH;
                if (model_ptr == 0) model_wrapped = 1;
                if (op == OP_LAST) model_mem[model_ptr] = 8'h00;
            end
            default: begin
                for (int i = 0; i <= len; i++) model_mem[(addr + i) % DEPTH] = 8'h00;
                model_ptr = addr;
            end
        endcase
    endtask

    // Issue one command, measure its busy window, then compare pointer state.
    task automatic run_cmd(input logic [1:0] op, input int addr, input logic [7:0] data,
                           input int len);
        int n;
        int exp_busy;
        @(negedge clk);
        check_val("ready_idle", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = AW'(addr);
        cmd_data  = data;
        cmd_len   = AW'(len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_data  = 8'($urandom);
        cmd_len   = AW'($urandom);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            check_val("ready_busy", {31'd0, cmd_ready}, 0);
            n++;
            @(posedge clk);
            #1;
        end
        model_apply(op, addr, data, len);
        exp_busy = (op == OP_LAST) ? 1 : (op == OP_CLR) ? len + 1 : 0;
        $display("cmd op=%0d addr=0x%03h data=0x%02h len=%0d busy_cycles=%0d wr_ptr=0x%03h",
                 op, addr, data, len, n, wr_ptr);
        check_val("busy_cycles", n, exp_busy);
        check_val("wr_ptr", {20'd0, wr_ptr}, model_ptr);
        check_val("wrapped", {31'd0, wrapped}, {31'd0, model_wrapped});
    endtask

    task automatic check_read(input int addr);
        @(negedge clk);
        char_addr = AW'(addr);
        @(posedge clk);
        #1;
        $display("read addr=0x%03h data=0x%02h", addr, char_data);
        check_val("char_data", {24'd0, char_data}, {24'd0, model_mem[addr]});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        int ra;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_SET;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_len   = '0;
        char_addr = '0;
        model_ptr = 0;
        model_wrapped = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_char_data", {24'd0, char_data}, 0);
        check_val("rst_wr_ptr", {20'd0, wr_ptr}, 0);
        check_val("rst_busy", {31'd0, busy}, 0);
        check_val("rst_wrapped", {31'd0, wrapped}, 0);
        check_val("rst_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        reset = 1'b0;

        // Fill the whole RAM with back-to-back PUT_CHARs, one per cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUT;
        cmd_data  = 8'($urandom);
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk);
            #1;
            model_apply(OP_PUT, 0, cmd_data, 0);
            cmd_data = 8'($urandom);
        end
        cmd_valid = 1'b0;
        $display("fill done wr_ptr=0x%03h wrapped=%0d", wr_ptr, wrapped);
        check_val("fill_wr_ptr", {20'd0, wr_ptr}, model_ptr);
        check_val("fill_wrapped", {31'd0, wrapped}, {31'd0, model_wrapped});
        for (int i = 0; i < 8; i++) check_read($urandom_range(0, DEPTH - 1));

        // "Hi" string with terminator.
        run_cmd(OP_SET, 'h010, 8'h00, 0);
        run_cmd(OP_PUT, 0, 8'h48, 0);
        run_cmd(OP_LAST, 0, 8'h69, 0);
        check_read('h011);
        for (int a = 'h010; a <= 'h012; a++) check_read(a);

        // CLEAR across the top of the address space.
        run_cmd(OP_SET, 'hFFE, 8'h00, 0);
        for (int i = 0; i < 4; i++) run_cmd(OP_PUT, 0, 8'hFF, 0);
        run_cmd(OP_CLR, 'hFFE, 8'h00, 3);
        check_read('hFFD);
        check_read('hFFE);
        check_read('hFFF);
        check_read('h000);
        check_read('h001);
        check_read('h002);

        // Pointer wrap and sticky flag.
        run_cmd(OP_SET, 'hFFF, 8'h00, 0);
        run_cmd(OP_PUT, 0, 8'h41, 0);
        run_cmd(OP_PUT, 0, 8'h41, 0);
        check_read('hFFF);
        check_read('h000);
        run_cmd(OP_SET, 'h300, 8'h00, 0);

        // Same-cycle read/write collision at 0x020 holding a terminator.
        run_cmd(OP_SET, 'h020, 8'h00, 0);
        run_cmd(OP_PUT, 0, 8'h00, 0);
        run_cmd(OP_SET, 'h020, 8'h00, 0);
        @(negedge clk);
        char_addr = AW'('h020);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUT;
        cmd_data  = 8'h5A;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
`ifdef STRBUF_WRFWD_EN
        d = 8'h5A;
`else
        d = model_mem['h020];
`endif
        model_apply(OP_PUT, 0, 8'h5A, 0);
        $display("collision addr=0x020 data=0x%02h", char_data);
        check_val("collision", {24'd0, char_data}, {24'd0, d});
        @(posedge clk);
        #1;
        check_val("collision_next", {24'd0, char_data}, 32'h5A);

        // Randomized command mix against the model.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            op = 2'($urandom_range(0, 3));
            run_cmd(op, $urandom_range(0, DEPTH - 1), 8'($urandom),
                    $urandom_range(0, 15));
            check_read($urandom_range(0, DEPTH - 1));
            ra = (model_ptr + DEPTH - 1) % DEPTH;
            check_read(ra);
            check_read(model_ptr);
        end

        // Reset in the middle of a long CLEAR.
        run_cmd(OP_SET, 'h100, 8'h00, 0);
        for (int i = 0; i < 10; i++) run_cmd(OP_PUT, 0, 8'(8'h80 + i), 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLR;
        cmd_addr  = AW'('h100);
        cmd_len   = AW'(9);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_mem['h100] = 8'h00;
        model_mem['h101] = 8'h00;
        model_ptr = 0;
        model_wrapped = 0;
        $display("reset mid-clear busy=%0d wr_ptr=0x%03h", busy, wr_ptr);
        check_val("abort_busy", {31'd0, busy}, 0);
        check_val("abort_wr_ptr", {20'd0, wr_ptr}, 0);
        check_val("abort_char_data", {24'd0, char_data}, 0);
        check_val("abort_wrapped", {31'd0, wrapped}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("abort_ready", {31'd0, cmd_ready}, 1);
        check_read('h100);
        check_read('h101);
        for (int a = 'h103; a <= 'h109; a++) check_read(a);
        run_cmd(OP_PUT, 0, 8'h33, 0);
        check_read(0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_cnt, miscompare_cnt);
        $finish;
    end

endmodule
